// File: rtl/demux_pkg.sv
// Shared definitions for the two-output stream demultiplexer.
// Defaults, per-output buffer states and output port indices.
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNTW_DEF  = 8;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry output buffer for the stream demultiplexer.
// r_head is always the oldest word; r_tail only holds data in FULL.
//
//   state | meaning
//   EMPTY | no word held, o_valid=0
//   ONE   | one word in r_head
//   FULL  | two words, r_head older than r_tail; pushes are refused upstream
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  buf_state_e       r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail  <= i_data;
            r_state <= FULL;
          end else if (i_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          // A push is never presented while full, so only the pop matters.
          if (i_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_state != EMPTY);
  assign o_full  = (r_state == FULL);

endmodule

// File: rtl/demux_stream.sv
// Routes an input stream to one of two buffered outputs chosen by select,
// and counts the words delivered on each output.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic w_sel1;
  logic w_full0;
  logic w_full1;
  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  assign w_sel1 = (select == 1'(PORT1));

  // Full refuses the push even when the same cycle pops; keeps FULL push-free.
  assign in_ready = w_sel1 ? !w_full1 : !w_full0;

  assign w_push0 = in_valid && in_ready && !w_sel1;
  assign w_push1 = in_valid && in_ready &&  w_sel1;
  assign w_pop0  = out0_valid && out0_ready;
  assign w_pop1  = out1_valid && out1_ready;

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_pop   (w_pop0),
    .i_data  (in_data),
    .o_data  (out0_data),
    .o_valid (out0_valid),
    .o_full  (w_full0)
  );

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_pop   (w_pop1),
    .i_data  (in_data),
    .o_data  (out1_data),
    .o_valid (out1_valid),
    .o_full  (w_full1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter CNTW, default 8, giving the per-output transfer counter width in bits.
Ports:
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 select  input  1  destination of in_data: 0 routes to out0, 1 routes to out1; sampled with in_data.
REQ-009 out0_valid / out1_valid  output  1  output holds a word.
REQ-010 out0_ready / out1_ready  input  1  downstream consumes the word.
REQ-011 out0_data / out1_data  output  WIDTH  head word of each output buffer.
REQ-012 cnt0 / cnt1  output  CNTW  words delivered on each output.

Function
REQ-013 Input handshake SHALL be in_valid && in_ready on a rising clk edge; output handshake SHALL be outN_valid && outN_ready.
REQ-014 Each output SHALL own a 2-entry FIFO buffer (depth fixed at 2).
REQ-015 in_ready SHALL equal "buffer selected by the current select is not full"; it SHALL depend combinationally on select only, never on in_valid.
REQ-016 An accepted word SHALL be written only to the selected buffer; the other buffer SHALL be unchanged.
REQ-017 Latency: an accepted word written to an empty buffer SHALL appear on outN_data with outN_valid=1 on the cycle after acceptance; there SHALL be no same-cycle pass-through.
REQ-018 outN_valid SHALL be 1 exactly when buffer N holds at least 1 word; outN_data SHALL be the oldest word in buffer N, with per-output FIFO order preserved.
REQ-019 Full boundary: when buffer N holds 2 words, in_ready SHALL be 0 for select=N even if outN_ready=1 that cycle, so a full buffer is never pushed and popped in the same cycle.
REQ-020 Simultaneous push and pop on a 1-entry buffer SHALL leave the occupancy at 1, with the new word at the head on the next cycle.
REQ-021 Pushing one buffer while popping the other in the same cycle SHALL both take effect.
REQ-022 Empty boundary: outN_ready while outN_valid=0 SHALL have no effect.
REQ-023 outN_data SHALL be held stable while outN_valid=1 and outN_ready=0.
REQ-024 cntN SHALL increment by 1 on each outN handshake and wrap modulo 2^CNTW (255 -> 0 at default).
REQ-025 Buffer state per output SHALL be one of three states: EMPTY, ONE, FULL.
REQ-026 State transitions SHALL be: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop; all other cases hold.

Reset
REQ-027 While rst_n=0: both buffers SHALL be EMPTY, out0_valid=out1_valid=0, cnt0=cnt1=0, and out0_data=out1_data=0.
REQ-028 in_ready SHALL be 1 during reset, because both buffers are empty.
REQ-029 Reset assertion mid-operation SHALL discard buffered words immediately (asynchronously); no partial transfer SHALL complete.
REQ-030 After rst_n deasserts, the first handshake SHALL be honoured on the first rising edge.

Structure
REQ-031 The shared package demux_pkg SHALL hold the default WIDTH and CNTW, the buffer-state enumeration (EMPTY/ONE/FULL), and the port-index constants PORT0=0 and PORT1=1.
REQ-032 The 2-entry buffer SHALL be a sub-module demux_fifo2 (push/pop/data/valid/full), instantiated twice.
REQ-033 The top level SHALL contain only select decode, the in_ready mux, and the counters.

Verification
REQ-034 Reset: assert rst_n=0 with buffers full -> next sample: outN_valid=0, cntN=0, in_ready=1.
REQ-035 Routing: push 0x11 (select=0) and 0xA5 (select=1) on consecutive cycles, outputs stalled -> out0_data=0x11, out1_data=0xA5, each valid 1 cycle after its push.
REQ-036 Full: push 0x01, 0x02, 0x03 to out0, out0_ready=0 -> third word stalls with in_ready=0; raise out0_ready -> order 0x01, 0x02, 0x03 with no loss or duplication.
REQ-037 Full with pop: out0 FULL, out0_ready=1, in_valid=1, select=0 -> in_ready=0, occupancy drops to ONE; push succeeds next cycle.
REQ-038 Independence: out1 FULL and stalled, stream 10 words to out0 with select=0 -> all accepted, cnt0=10, cnt1 unchanged.
REQ-039 Wrap: 256 handshakes on out1 -> cnt1 returns to 0x00; mid-stream rst_n pulse -> buffers empty and counts 0.
